// File: rtl/udlx_pkg.sv
// Shared types and constants for the uDLX pipeline control slice.
package udlx_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
  parameter int W = udlx_pkg::CNT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// uDLX pipeline sequencer: PC/pipeline-register enables, stalls and flushes with
// priority memory-wait > redirect > flush window > load-use, plus perf counters.
module pipeline_ctrl
  import udlx_pkg::*;
#(
  parameter int PC_DATA_WIDTH  = 20,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      imem_ready,
  input  logic                      dmem_busy,
  input  logic                      branch_taken,
  input  logic [PC_DATA_WIDTH-1:0]  branch_target,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      cnt_clr,
  output logic                      pc_en,
  output logic                      pc_redirect,
  output logic [PC_DATA_WIDTH-1:0]  pc_redirect_addr,
  output logic                      if_id_en,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_en,
  output logic                      id_ex_flush,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  ctrl_state_e               state_q, state_d;
  logic [3:0]                fcnt_q, fcnt_d;
  logic                      pend_q, pend_d;
  logic [PC_DATA_WIDTH-1:0]  pend_addr_q, pend_addr_d;

  logic                      mem_stall;
  logic                      redir;
  logic                      lu_hit;
  logic                      lu_stall;
  logic [PC_DATA_WIDTH-1:0]  redir_tgt;

  assign mem_stall = !imem_ready || dmem_busy;
  assign redir     = branch_taken || pend_q;
  assign redir_tgt = pend_q ? pend_addr_q : branch_target;
  assign lu_hit    = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (mem_stall) begin
      // Frozen pipeline: remember the most recent EX redirect for later.
      if (branch_taken) begin
        pend_d      = 1'b1;
        pend_addr_d = branch_target;
      end
    end else if (redir) begin
      pend_d = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = 4'(FLUSH_CYCLES - 1);
      end else begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    end else if (state_q == ST_FLUSH) begin
      fcnt_d = fcnt_q - 4'd1;
      if (fcnt_q == 4'd1) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    pc_en            = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    if_id_en         = 1'b0;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_en         = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_en        = 1'b0;
    mem_wb_en        = 1'b0;
    lu_stall         = 1'b0;
    if (mem_stall) begin
      lu_stall = 1'b0;
    end else if (redir) begin
      pc_en            = 1'b1;
      pc_redirect      = 1'b1;
      pc_redirect_addr = redir_tgt;
      if_id_en         = 1'b1;
      if_id_flush      = 1'b1;
      id_ex_en         = 1'b1;
      id_ex_flush      = 1'b1;
      ex_mem_en        = 1'b1;
      mem_wb_en        = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else if (lu_hit) begin
      // Hold PC and IF/ID, inject one bubble into EX.
      lu_stall    = 1'b1;
      if_id_en    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_stall || lu_stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule
